// File: rtl/ifu_pkg.sv
// Shared widths, constants and the fetch-entry layout for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head entry always sits in register slot 0,
// so the head output comes straight from a flop.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    wr_idx  = do_pop ? cnt - 1'b1 : cnt;

    mem_nxt = mem;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_nxt[i] = mem[i+1];
      end
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          mem_nxt[i] = push_data;
        end
      end
    end

    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      mem <= mem_nxt;
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: credit-limited in-order requests, PC tag queue, registered
// instruction buffer, and flush handling that drops stale responses by count.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_hold_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_resp_valid_i,
  input  logic [ILEN-1:0] imem_resp_data_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   tag_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic            credit;
  logic            req_fire;
  logic            resp_live;
  logic            inst_pop;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    buf_in;
  fetch_entry_t    buf_head;

  // Counting buffered plus outstanding entries guarantees a slot for every live response.
  assign credit = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);

  assign imem_req_valid_o = !rst && !flush_i && credit;
  assign imem_req_addr_o  = {pc_i[XLEN-1:2], 2'b00};
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign pc_hold_o        = !req_fire && !flush_i;

  assign resp_live = imem_resp_valid_i && (drop_cnt == '0) && !flush_i && (tag_cnt != '0);
  assign inst_pop  = inst_valid_o && inst_ready_i && !flush_i;

  assign buf_in.pc   = tag_head;
  assign buf_in.inst = imem_resp_data_i;

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_i),
    .push      (req_fire),
    .push_data (pc_i),
    .pop       (resp_live),
    .head      (tag_head),
    .cnt       (tag_cnt)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_i),
    .push      (resp_live),
    .push_data (buf_in),
    .pop       (inst_pop),
    .head      (buf_head),
    .cnt       (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case ({req_fire, imem_resp_valid_i})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      // out_cnt already includes earlier stale requests, so it replaces drop_cnt outright.
      if (flush_i) begin
        drop_cnt <= imem_resp_valid_i ? out_cnt - 1'b1 : out_cnt;
      end else if (imem_resp_valid_i && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  assign inst_valid_o = (fifo_cnt != '0);
  assign inst_o       = buf_head.inst;
  assign inst_pc_o    = buf_head.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a latency-configurable in-order memory, a PC
// generator model and a scoreboard of live PCs that flushes discard wholesale.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_i;
  logic            pc_hold_o;
  logic            flush_i;
  logic            imem_req_valid_o;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_req_ready_i;
  logic            imem_resp_valid_i;
  logic [ILEN-1:0] imem_resp_data_i;
  logic            inst_valid_o;
  logic [ILEN-1:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_ready_i;

  always #5 clk = ~clk;

  ifu_fetch #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .pc_hold_o         (pc_hold_o),
    .flush_i           (flush_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .inst_pc_o         (inst_pc_o),
    .inst_ready_i      (inst_ready_i)
  );

  typedef struct { int due; logic [ILEN-1:0] data; } mem_rsp_t;
  typedef struct { logic [XLEN-1:0] pc; logic [ILEN-1:0] inst; } exp_t;

  mem_rsp_t        mem_q[$];
  exp_t            exp_q[$];
  int              cyc = 0;
  int              last_due = 0;
  int              n_chk = 0;
  int              n_pass = 0;
  int              lat = 1;
  int              req_mode = 0;
  int              dec_mode = 0;
  bit              nop_mode = 1'b1;
  bit              have_last = 1'b0;
  logic            tb_rst = 1'b1;
  logic            flush_req = 1'b0;
  logic [XLEN-1:0] flush_tgt = '0;
  logic [XLEN-1:0] pc_model = 64'h8000_0000;
  logic [XLEN-1:0] last_addr = '0;

  function automatic logic [ILEN-1:0] mem_data(logic [XLEN-1:0] a);
    return nop_mode ? NOP : (a[31:0] ^ a[63:32] ^ 32'h5a5a_0f0f);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic pick(int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, advance the models.
  task automatic step();
    bit              fire;
    bit              pop;
    logic [XLEN-1:0] a;
    exp_t            e;
    mem_rsp_t        r;
    @(negedge clk);
    rst               = tb_rst;
    flush_i           = flush_req;
    pc_i              = pc_model;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    if (tb_rst) begin
      mem_q.delete();
      last_due = cyc;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    imem_req_ready_i = pick(req_mode);
    inst_ready_i     = pick(dec_mode);
    #1;
    fire = imem_req_valid_o && imem_req_ready_i;
    pop  = inst_valid_o && inst_ready_i;
    if (tb_rst) begin
      chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
      exp_q.delete();
      have_last = 1'b0;
    end else if (flush_i) begin
      chk("flush_req_valid", 64'(imem_req_valid_o), 64'd0);
      chk("flush_hold", 64'(pc_hold_o), 64'd0);
      exp_q.delete();
      have_last = 1'b0;
    end else begin
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("spurious_inst", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc_o, e.pc);
          chk("inst", 64'(inst_o), 64'(e.inst));
        end
      end
      if (fire) begin
        a = {pc_model[XLEN-1:2], 2'b00};
        chk("req_addr", imem_req_addr_o, a);
        chk("hold_on_fire", 64'(pc_hold_o), 64'd0);
        if (have_last) chk("pc_seq", imem_req_addr_o, last_addr + 64'd4);
        last_addr = imem_req_addr_o;
        have_last = 1'b1;
        e.pc   = pc_model;
        e.inst = mem_data(a);
        exp_q.push_back(e);
        r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.data = e.inst;
        mem_q.push_back(r);
        last_due = r.due;
      end else begin
        chk("hold_idle", 64'(pc_hold_o), 64'd1);
      end
    end
    if (flush_i) pc_model = flush_tgt;
    else if (!pc_hold_o) pc_model = pc_model + 64'd4;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    bit found;
    rst = 1'b1; pc_i = '0; flush_i = 1'b0; imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0; imem_resp_data_i = '0; inst_ready_i = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", inst_pc_o, 64'd0);
    chk("rst_hold", 64'(pc_hold_o), 64'd1);

    // Zero-wait memory, first instruction latency
    tb_rst = 1'b0;
    step();
    chk("first_req_valid", 64'(imem_req_valid_o), 64'd1);
    step();
    step();
    chk("lat_inst_valid", 64'(inst_valid_o), 64'd1);
    chk("lat_inst_pc0", inst_pc_o, 64'h8000_0000);
    chk("lat_inst_nop", 64'(inst_o), 64'(NOP));
    step();
    chk("lat_inst_pc1", inst_pc_o, 64'h8000_0004);

    // Decode stall fills the buffer and removes credit
    dec_mode = 2;
    repeat (5) step();
    chk("stall_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("stall_hold", 64'(pc_hold_o), 64'd1);
    chk("stall_inst_valid", 64'(inst_valid_o), 64'd1);
    dec_mode = 0;
    repeat (12) step();

    // Flush with two stale requests in flight
    nop_mode = 1'b0;
    lat = 3;
    repeat (10) step();
    flush_req = 1'b1;
    flush_tgt = 64'h8000_1000;
    step();
    flush_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (inst_valid_o) begin
        found = 1'b1;
        chk("flush_first_pc", inst_pc_o, 64'h8000_1000);
      end
    end
    chk("flush_first_seen", 64'(found), 64'd1);
    repeat (10) step();

    // Flush coinciding with a response and a decode pop
    lat = 2;
    repeat (6) step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (inst_valid_o && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
      else step();
    end
    chk("f4_setup", 64'(found), 64'd1);
    flush_req = 1'b1;
    flush_tgt = 64'h8000_3000;
    step();
    flush_req = 1'b0;
    chk("f4_resp", 64'(imem_resp_valid_i), 64'd1);
    chk("f4_pop_req", 64'(inst_valid_o && inst_ready_i), 64'd1);
    stale = mem_q.size();
    @(posedge clk);
    #1;
    chk("f4_drop_cnt", 64'(dut.drop_cnt), 64'(stale));
    step();
    chk("f4_empty", 64'(inst_valid_o), 64'd0);

    // Random ready, random decode, random latency, occasional flush
    req_mode = 1;
    dec_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        flush_req = 1'b1;
        flush_tgt = {32'($urandom()), 32'($urandom()) & 32'hFFFF_FFFC};
        if ($urandom_range(0, 1) == 1) flush_tgt = flush_tgt | 64'd2;
      end
      step();
      flush_req = 1'b0;
    end
    flush_req = 1'b0;
    repeat (20) step();

    // Reset mid-stream with the buffer full
    req_mode = 0;
    dec_mode = 2;
    lat = 1;
    repeat (6) step();
    chk("prerst_full", 64'(inst_valid_o), 64'd1);
    tb_rst = 1'b1;
    step();
    chk("midrst_hold", 64'(pc_hold_o), 64'd1);
    tb_rst = 1'b0;
    pc_model = 64'h8000_2000;
    dec_mode = 0;
    step();
    chk("postrst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("postrst_inst", 64'(inst_o), 64'd0);
    chk("postrst_inst_pc", inst_pc_o, 64'd0);
    chk("postrst_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("postrst_addr", imem_req_addr_o, 64'h8000_2000);
    repeat (10) step();

    // Drain: everything issued must have reached decode
    req_mode = 2;
    repeat (20) step();
    chk("drain_exp", 64'(exp_q.size()), 64'd0);
    chk("drain_mem", 64'(mem_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
